aes_inv_cipher_top: RTL and testbench

AES-128 inverse cipher: decrypts one 128-bit ciphertext block per load using a key schedule expanded once and held locally. Iterative, one round per clock, built on the team's `aes_key_expand_128` expander and 16 `aes_inv_sbox` instances. It is the decrypt-side counterpart of the encrypt core. Byte order, column-major state layout and round-key word layout are identical to the encrypt core, so {key, ciphertext} pairs interoperate directly.

---
 rtl/aes_inv_cipher_top.sv | 231 +++++++++++++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_top.sv
// AES-128 inverse cipher: 11-entry local key schedule, one decryption round per clock.
// Latency: kdone 11 cycles after kld, done 10 cycles after ld; no backpressure (ld restarts, kld aborts).

package aes_inv_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction
endpackage

// Forward AES S-box, used by the key expander.
// Combinational; no backpressure.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    logic [7:0] x;
    assign x = gf_inv(a);
    assign y = x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
endmodule

// Inverse AES S-box: inverse affine transform followed by field inversion.
// Combinational; no backpressure.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    logic [7:0] t;
    assign t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    assign y = gf_inv(t);
endmodule

// AES-128 key expander: wo holds RK0 after the kld edge, then the next round key every clock.
// Latency: one round key per cycle; free-running, no backpressure.
module aes_key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [127:0] wo
);
    logic [3:0]  rc;
    logic [7:0]  rcon;
    logic [31:0] rot, sub, t, n0, n1, n2, n3;

    assign rot = {wo[23:0], wo[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sb
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    always_comb begin
        rcon = 8'h00;
        case (rc)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sub ^ {rcon, 24'h000000};
    assign n0 = wo[127:96] ^ t;
    assign n1 = wo[95:64]  ^ n0;
    assign n2 = wo[63:32]  ^ n1;
    assign n3 = wo[31:0]   ^ n2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wo <= '0;
            rc <= '0;
        end else if (kld) begin
            wo <= key;
            rc <= '0;
        end else begin
            wo <= {n0, n1, n2, n3};
            if (rc != 4'd10) rc <= rc + 4'd1;
        end
    end
endmodule

// AES-128 inverse cipher top: key schedule captured once, then iterative decryption.
// Latency: kdone 11 cycles after kld; done pulses 10 cycles after ld; ld re-starts, kld aborts.
module aes_inv_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         kdone,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);
    import aes_inv_pkg::*;

    logic [127:0] kb [0:10];
    logic [127:0] kw;
    logic [127:0] sa, isr, isb, ark, imc;
    logic [3:0]   rnd;
    logic [3:0]   kidx;
    logic         kact;

    aes_key_expand_128 u_kexp (.clk(clk), .rst(rst), .kld(kld), .key(key), .wo(kw));

    // Byte (r,c) lives at bit offset 8*(r+4c) from the MSB.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign isr[127-8*(r+4*c) -: 8] = sa[127-8*(r+4*((c-r+4)%4)) -: 8];
            aes_inv_sbox u_isb (.a(isr[127-8*(r+4*c) -: 8]), .y(isb[127-8*(r+4*c) -: 8]));
        end
    end

    assign ark = isb ^ kb[rnd];

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    always_ff @(posedge clk) begin
        if (rst && !kld && kact) kb[kidx] <= kw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            kdone    <= 1'b0;
            kact     <= 1'b0;
            kidx     <= '0;
            rnd      <= '0;
            sa       <= '0;
            text_out <= '0;
        end else begin
            done <= 1'b0;
            if (kld) begin
                kact  <= 1'b1;
                kidx  <= '0;
                kdone <= 1'b0;
                busy  <= 1'b0;
            end else begin
                if (kact) begin
                    kidx <= kidx + 4'd1;
                    if (kidx == 4'd10) begin
                        kact  <= 1'b0;
                        kdone <= 1'b1;
                    end
                end
                // A fresh block always wins over the one in flight.
                if (ld && kdone) begin
                    sa   <= text_in ^ kb[10];
                    rnd  <= 4'd9;
                    busy <= 1'b1;
                end else if (busy) begin
                    if (rnd == 4'd0) begin
                        text_out <= ark;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        sa  <= imc;
                        rnd <= rnd - 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: known-answer and random vectors against a forward-cipher model.
module tb_aes_inv_cipher_top;
    logic         clk = 1'b0;
    logic         rst, kld, ld;
    logic [127:0] key, text_in;
    logic         kdone, busy, done;
    logic [127:0] text_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [0:255];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [6];

    aes_inv_cipher_top dut (
        .clk(clk), .rst(rst), .kld(kld), .key(key), .kdone(kdone),
        .ld(ld), .text_in(text_in), .busy(busy), .done(done), .text_out(text_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic: schoolbook carry-less product then polynomial reduction.
    function automatic logic [7:0] mulslow(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (mulslow(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a] = s;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] v, input int k);
        return v[127-8*k -: 8];
    endfunction

    function automatic logic [127:0] pb(input logic [127:0] v, input int k, input logic [7:0] b);
        logic [127:0] r;
        r = v;
        r[127-8*k -: 8] = b;
        return r;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a [4];
        logic [127:0] s, n;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
                rc = mulslow(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int rd = 1; rd <= 10; rd++) begin
            n = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    n = pb(n, r + 4*c, sb[gb(s, r + 4*((c + r) % 4))]);
            s = n;
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = gb(n, 4*c + r);
                    for (int r = 0; r < 4; r++)
                        s = pb(s, 4*c + r, mulslow(a[r], 8'h02) ^ mulslow(a[(r+1)%4], 8'h03)
                                           ^ a[(r+2)%4] ^ a[(r+3)%4]);
                end
            end
            s = s ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k, input string nm);
        int n;
        kld = 1'b1;
        key = k;
        tick();
        kld = 1'b0;
        chk({nm, "_kdone_low"}, kdone, 0);
        n = 0;
        while (!kdone && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_kdone_lat"}, n, 11);
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string nm);
        int n;
        ld      = 1'b1;
        text_in = ct;
        tick();
        ld = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_done_after_ld"}, done, 0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, n, 10);
        chk({nm, "_pt"}, text_out, pt);
        chk({nm, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int  n;
        logic saw;
        rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
        build_sbox();
        tick();
        tick();
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_kdone", kdone, 0);
        chk("rst_text_out", text_out, 0);
        rst = 1'b1;
        tick();

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        for (int i = 2; i < 6; i++) begin
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = ref_encrypt(vecs[i].key, vecs[i].pt);
        end

        for (int i = 0; i < 6; i++) begin
            load_key(vecs[i].key, $sformatf("v%0d", i));
            run_block(vecs[i].ct, vecs[i].pt, $sformatf("v%0d", i));
        end

        // App. B key reused with a second ld on the cycle after done.
        load_key(vecs[1].key, "b2b");
        run_block(vecs[1].ct, vecs[1].pt, "b2b_first");
        run_block(vecs[1].ct, vecs[1].pt, "b2b_second");
        for (int j = 0; j < 4; j++) begin
            logic [127:0] p;
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(ref_encrypt(vecs[1].key, p), p, $sformatf("rnd_same_key%0d", j));
        end

        // ld five cycles into the key phase is ignored.
        kld = 1'b1; key = vecs[0].key;
        tick();
        kld = 1'b0;
        repeat (4) tick();
        ld = 1'b1; text_in = vecs[0].ct;
        tick();
        ld = 1'b0;
        chk("early_ld_busy", busy, 0);
        saw = 1'b0;
        n = 0;
        while (!kdone && n < 20) begin
            if (done || busy) saw = 1'b1;
            tick();
            n++;
        end
        chk("early_ld_ignored", saw, 0);
        chk("early_ld_kdone_lat", n, 6);
        run_block(vecs[0].ct, vecs[0].pt, "early_then_ok");

        // Re-ld four cycles after the first ld aborts block A.
        load_key(vecs[1].key, "abort");
        ld = 1'b1; text_in = vecs[0].ct;
        tick();
        ld = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            if (done) saw = 1'b1;
            tick();
        end
        chk("abort_no_early_done", saw, 0);
        run_block(vecs[1].ct, vecs[1].pt, "abort_b");
        tick();
        chk("abort_single_done", done, 0);

        // kld three cycles after ld aborts the decrypt.
        load_key(vecs[0].key, "kmid");
        ld = 1'b1; text_in = vecs[0].ct;
        tick();
        ld = 1'b0;
        tick();
        tick();
        kld = 1'b1; key = vecs[0].key;
        tick();
        kld = 1'b0;
        chk("kmid_busy", busy, 0);
        chk("kmid_kdone", kdone, 0);
        saw = 1'b0;
        n = 0;
        while (!kdone && n < 20) begin
            if (done) saw = 1'b1;
            tick();
            n++;
        end
        chk("kmid_no_done", saw, 0);
        chk("kmid_kdone_lat", n, 11);
        run_block(vecs[0].ct, vecs[0].pt, "kmid_after");

        // Reset at L5.
        ld = 1'b1; text_in = vecs[0].ct;
        tick();
        ld = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_done", done, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_kdone", kdone, 0);
        chk("mrst_text_out", text_out, 0);
        ld = 1'b1; text_in = vecs[0].ct;
        tick();
        ld = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            if (done || busy) saw = 1'b1;
            tick();
        end
        chk("mrst_ld_ignored", saw, 0);
        load_key(vecs[3].key, "mrst_reload");
        run_block(vecs[3].ct, vecs[3].pt, "mrst_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
